hello_world_qsys_switch_ctrl: RTL
=================================

Name: hello_world_qsys_switch_ctrl

Overview:
Avalon-MM slave controller for the board slide switches. It replaces the raw switch PIO read path with a sequenced one:
- 2-flop synchronizer, then a per-bit debounce FSM.
- Edge-capture register with write-1-to-clear.
- Maskable interrupt to the Nios II.
- Debounce period programmable at runtime.

Sits between the switch pins and the Qsys interconnect, in place of the bare switch PIO.

Parameters:
WIDTH, 2, number of switch inputs (1..16)
DEBOUNCE_DEFAULT, 1000, reset value of the debounce period register, in clk cycles (16-bit)
EDGE_TYPE, 2, capture mode: 0 rising, 1 falling, 2 any edge

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
address  input  2  Avalon register select
chipselect  input  1  Avalon slave select
write_n  input  1  active-low write strobe
writedata  input  32  write data
in_port  input  WIDTH  raw, asynchronous switch pins
readdata  output  32  registered read data
irq  output  1  level interrupt, active high

Behaviour:
- Single clock domain, clk only. reset_n is asynchronous active-low: asserting it clears all flops immediately.
- Reset values:
  - readdata=0, irq=0.
  - Sync flops=0, debounced state=0, counters=0.
  - irq_mask=0, edge_capture=0, db_period=DEBOUNCE_DEFAULT.
- Register map (word addresses):
  - 0: debounced state. RO in bits [WIDTH-1:0]; other bits read 0.
  - 1: irq_mask. RW in bits [WIDTH-1:0].
  - 2: edge_capture. Read returns flags; write 1 clears the corresponding bit.
  - 3: db_period. RW in bits [15:0].
- Read: readdata is updated every clk with the mux output for the current address.
  - 1-cycle read latency, no wait states, no side effects on read.
  - chipselect is not required for read.
- Write: takes effect at the clk edge where chipselect=1 and write_n=0.
- Synchronizer: sync1 <= in_port; sync2 <= sync1.
- Per-bit debounce FSM, states STABLE and COUNTING:
  - STABLE: if sync2[i] != deb[i], go to COUNTING with cnt=1. Otherwise stay.
  - COUNTING: if sync2[i] == deb[i] (bounce), go to STABLE with cnt=0.
  - COUNTING: else if cnt >= eff_period, then deb[i] <= sync2[i], cnt=0, go to STABLE. Otherwise cnt++.
  - eff_period = max(db_period, 1). db_period=0 behaves as 1.
  - Counter is 16-bit and saturates; it never wraps.
- Latency: a clean step on in_port[i] reaches deb[i] 2+eff_period cycles after the first capturing edge. It is visible in readdata one cycle later.
- db_period written mid-count: the new value applies immediately to the comparison. If cnt already exceeds it, the update fires on the next cycle.
- Edge detect: deb_change[i] = deb[i] updated this cycle, qualified by EDGE_TYPE. It sets edge_capture[i] on the following edge.
- Simultaneous set and write-1-clear of the same bit: set wins.
- irq = |(edge_capture & irq_mask). It is a combinational AND/OR of flops only, so there is no extra latency.
- Changing irq_mask affects irq in the same cycle the register updates.

Optional Feature:
SWITCH_CTRL_EVENT_CNT_EN
- Defined:
  - Address 0 bits [31:16] return a 16-bit count of debounce updates (any bit, any direction).
  - The count wraps 0xFFFF->0x0000.
  - Multiple bits updating in the same cycle count once.
  - Any write to address 0 clears the count; an increment in the same cycle is lost, because the clear wins.
- Undefined: bits [31:16] of address 0 read 0, writes to address 0 are ignored, and no counter logic is present.

Test Plan:
- Reset check: assert reset_n=0 mid-count with in_port=2'b11 -> readdata=0, irq=0, and a read of addr 3 returns 1000 after release.
- Clean step: db_period=4, in_port 00->01 -> addr 0 reads 1 on the read issued 6 cycles after the step (2 sync + 4 debounce); edge_capture=01.
- Bounce rejection: db_period=10, toggle in_port[0] every 3 cycles for 30 cycles, then hold at 0 -> deb stays 0, edge_capture=0, irq=0.
- IRQ path: mask=2'b10, generate an edge on bit 1 -> irq=1. Write addr 2 with 0x1 -> irq stays 1. Write 0x2 -> irq=0 on the next cycle.
- Set/clear collision: write 0x1 to addr 2 in the exact cycle bit 0 captures a new edge -> edge_capture[0]=1 afterwards.
- db_period=0 and event counter (macro defined): apply 3 steps on bit 0 -> each step passes after 3 cycles; addr 0 [31:16]=3. Write addr 0 -> reads 0.

Source files
------------

// File: rtl/hello_world_qsys_switch_ctrl_if.sv
// Avalon-MM slave bus and interrupt line between the Qsys interconnect and the
// slide-switch controller.
interface hello_world_qsys_switch_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/hello_world_qsys_switch_ctrl.sv
// Slide-switch controller: 2-flop sync, per-bit debounce, W1C edge capture, maskable irq.
// Optional macro SWITCH_CTRL_EVENT_CNT_EN adds a debounce-update counter in address 0 [31:16].
module hello_world_qsys_switch_ctrl #(
  parameter int WIDTH            = 2,
  parameter int DEBOUNCE_DEFAULT = 1000,
  parameter int EDGE_TYPE        = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [WIDTH-1:0]             in_port,
  hello_world_qsys_switch_ctrl_if.slave bus
);

  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } db_state_t;

  localparam logic [15:0] PERIOD_RST = 16'(DEBOUNCE_DEFAULT);

  logic [WIDTH-1:0] sync_p1;
  logic [WIDTH-1:0] sync_p2;
  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] fire;
  logic [WIDTH-1:0] deb_chg;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] clr_mask;
  db_state_t        st  [WIDTH];
  logic [15:0]      cnt [WIDTH];
  logic [15:0]      db_period;
  logic [15:0]      eff_period;
  logic             wr_en;
  logic [31:0]      rd_mux;
  logic             unused_wd;

  function automatic logic [WIDTH-1:0] qualify_edges(input logic [WIDTH-1:0] upd,
                                                     input logic [WIDTH-1:0] new_val);
    case (EDGE_TYPE)
      0:       return upd & new_val;
      1:       return upd & ~new_val;
      default: return upd;
    endcase
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign wr_en      = bus.chipselect & ~bus.write_n;
  assign eff_period = (db_period == 16'd0) ? 16'd1 : db_period;
  assign clr_mask   = (wr_en && bus.address == 2'd2) ? bus.writedata[WIDTH-1:0] : '0;
  assign unused_wd  = ^bus.writedata[31:16];

  // Synchronizer stages
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p1 <= '0;
      sync_p2 <= '0;
    end else begin
      sync_p1 <= in_port;
      sync_p2 <= sync_p1;
    end
  end

  // A bit commits when it has disagreed with deb for longer than the period;
  // the period is read live so a mid-count rewrite takes effect at once.
  always_comb begin
    fire = '0;
    for (int i = 0; i < WIDTH; i++) begin
      fire[i] = (st[i] == COUNTING) && (sync_p2[i] != deb[i]) && (cnt[i] >= eff_period);
    end
  end

  // Debounce FSM stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb     <= '0;
      deb_chg <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        st[i]  <= STABLE;
        cnt[i] <= '0;
      end
    end else begin
      deb     <= deb ^ fire;
      deb_chg <= qualify_edges(fire, sync_p2);
      for (int i = 0; i < WIDTH; i++) begin
        case (st[i])
          STABLE: begin
            if (sync_p2[i] != deb[i]) begin
              st[i]  <= COUNTING;
              cnt[i] <= 16'd1;
            end
          end
          COUNTING: begin
            if (sync_p2[i] == deb[i] || fire[i]) begin
              st[i]  <= STABLE;
              cnt[i] <= '0;
            end else begin
              cnt[i] <= sat_inc(cnt[i]);
            end
          end
          default: begin
            st[i]  <= STABLE;
            cnt[i] <= '0;
          end
        endcase
      end
    end
  end

  // Register file stage; a capture arriving with a W1C of the same bit wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask  <= '0;
      edge_cap  <= '0;
      db_period <= PERIOD_RST;
    end else begin
      edge_cap <= (edge_cap & ~clr_mask) | deb_chg;
      if (wr_en && bus.address == 2'd1) irq_mask  <= bus.writedata[WIDTH-1:0];
      if (wr_en && bus.address == 2'd3) db_period <= bus.writedata[15:0];
    end
  end

`ifdef SWITCH_CTRL_EVENT_CNT_EN
  logic [15:0] evt_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      evt_cnt <= '0;
    end else if (wr_en && bus.address == 2'd0) begin
      evt_cnt <= '0;
    end else if (|fire) begin
      evt_cnt <= evt_cnt + 16'd1;
    end
  end
`endif

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      2'd0: begin
        rd_mux[WIDTH-1:0] = deb;
`ifdef SWITCH_CTRL_EVENT_CNT_EN
        rd_mux[31:16]     = evt_cnt;
`endif
      end
      2'd1:    rd_mux[WIDTH-1:0] = irq_mask;
      2'd2:    rd_mux[WIDTH-1:0] = edge_cap;
      default: rd_mux[15:0]      = db_period;
    endcase
  end

  // Read data stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= '0;
    end else begin
      bus.readdata <= rd_mux;
    end
  end

  assign bus.irq = |(edge_cap & irq_mask);

endmodule
